// File: rtl/memory_access_module_pkg.sv
// lc3b_types: shared LC-3b word, control-word and MEM-stage state types.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        logic dmem_read;
        logic dmem_write;
        logic mem_indirect;
        logic mem_byte;
        logic load_regfile;
    } lc3b_control;

    typedef enum logic [1:0] {IDLE, IND_READ, ACCESS} lc3b_mem_state;

    function automatic lc3b_word word_align(input lc3b_word a);
        return {a[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/memory_access_module_mem_align.sv
// mem_align: byte-lane steering for data-memory requests and load extraction.
module mem_align
    import lc3b_types::*;
(
    input  lc3b_word   base_addr_i,
    input  logic       byte_i,
    input  lc3b_word   store_data_i,
    input  lc3b_word   rdata_i,
    output lc3b_word   addr_o,
    output logic [1:0] byte_enable_o,
    output lc3b_word   wdata_o,
    output lc3b_word   load_data_o
);
    logic [7:0] lane;

    assign lane          = base_addr_i[0] ? rdata_i[15:8] : rdata_i[7:0];
    assign addr_o        = byte_i ? base_addr_i : word_align(base_addr_i);
    assign byte_enable_o = byte_i ? (base_addr_i[0] ? 2'b10 : 2'b01) : 2'b11;
    assign wdata_o       = byte_i ? {store_data_i[7:0], store_data_i[7:0]} : store_data_i;
    assign load_data_o   = byte_i ? {{8{lane[7]}}, lane} : rdata_i;
endmodule

// File: rtl/memory_access_module.sv
// memory_access_module: LC-3b MEM stage running the data-memory handshake,
// stalling the front of the pipe and loading the MEM/WB register.
module memory_access_module
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  lc3b_word    alu_in,
    input  lc3b_word    store_data_in,
    input  lc3b_word    curr_ir_in,
    input  lc3b_word    curr_pc_in,
    input  lc3b_control control_word_in,
    input  logic        dmem_resp,
    input  lc3b_word    dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output lc3b_word    dmem_address,
    output lc3b_word    dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic        mem_stall,
    output logic        wb_valid,
    output lc3b_word    wb_ir,
    output lc3b_word    wb_pc,
    output lc3b_control wb_control,
    output lc3b_word    wb_alu,
    output lc3b_word    wb_mem_data,
    output logic [2:0]  MEM_WB_dest,
    output lc3b_word    MEM_WB_val,
    output logic        MEM_WB_regwrite
);
    lc3b_mem_state state_q, state_d;
    lc3b_word      ptr_q, ptr_d, mem_data_d;
    lc3b_word      base_addr, acc_addr, acc_wdata, load_data;
    logic [1:0]    acc_be;
    logic          memop, wb_load;
    logic          wb_valid_q;
    lc3b_word      wb_ir_q, wb_pc_q, wb_alu_q, wb_mem_data_q;
    lc3b_control   wb_control_q;

    assign memop     = valid_in & (control_word_in.dmem_read | control_word_in.dmem_write);
    assign base_addr = control_word_in.mem_indirect ? ptr_q : alu_in;

    mem_align u_align (
        .base_addr_i  (base_addr),
        .byte_i       (control_word_in.mem_byte),
        .store_data_i (store_data_in),
        .rdata_i      (dmem_rdata),
        .addr_o       (acc_addr),
        .byte_enable_o(acc_be),
        .wdata_o      (acc_wdata),
        .load_data_o  (load_data)
    );

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        wb_load          = 1'b0;
        mem_data_d       = '0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = '0;
        mem_stall        = 1'b0;
        case (state_q)
            IDLE: begin
                mem_stall = memop;
                wb_load   = ~memop;
                state_d   = ~memop ? IDLE : (control_word_in.mem_indirect ? IND_READ : ACCESS);
            end
            IND_READ: begin
                mem_stall        = 1'b1;
                dmem_read        = 1'b1;
                dmem_address     = word_align(alu_in);
                dmem_byte_enable = 2'b11;
                ptr_d            = dmem_resp ? dmem_rdata : ptr_q;
                state_d          = dmem_resp ? ACCESS : IND_READ;
            end
            ACCESS: begin
                dmem_read        = control_word_in.dmem_read;
                dmem_write       = control_word_in.dmem_write;
                dmem_address     = acc_addr;
                dmem_wdata       = acc_wdata;
                dmem_byte_enable = acc_be;
                mem_stall        = ~dmem_resp;
                wb_load          = dmem_resp;
                mem_data_d       = load_data;
                state_d          = dmem_resp ? IDLE : ACCESS;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            wb_valid_q    <= 1'b0;
            wb_ir_q       <= '0;
            wb_pc_q       <= '0;
            wb_control_q  <= '0;
            wb_alu_q      <= '0;
            wb_mem_data_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (wb_load) begin
                wb_valid_q    <= valid_in;
                wb_ir_q       <= curr_ir_in;
                wb_pc_q       <= curr_pc_in;
                wb_control_q  <= control_word_in;
                wb_alu_q      <= alu_in;
                wb_mem_data_q <= mem_data_d;
            end
        end
    end

    assign wb_valid        = wb_valid_q;
    assign wb_ir           = wb_ir_q;
    assign wb_pc           = wb_pc_q;
    assign wb_control      = wb_control_q;
    assign wb_alu          = wb_alu_q;
    assign wb_mem_data     = wb_mem_data_q;
    assign MEM_WB_dest     = wb_ir_q[11:9];
    assign MEM_WB_val      = wb_control_q.dmem_read ? wb_mem_data_q : wb_alu_q;
    assign MEM_WB_regwrite = wb_valid_q & wb_control_q.load_regfile;
endmodule
